// File: rtl/pc_target_pkg.sv
// rtl/pc_target_pkg.sv - shared mode encoding and default widths for the PC target unit
package pc_target_pkg;

    localparam int DEF_WORD_SIZE    = 16;
    localparam int DEF_JUMP_FIELD_W = 12;

    typedef enum logic [2:0] {
        SEQ    = 3'd0,
        BRANCH = 3'd1,
        JMP    = 3'd2,
        JAL    = 3'd3,
        JR     = 3'd4,
        RET    = 3'd5
    } tgt_mode_t;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack; push when full overwrites the oldest entry
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_top_idx;

    // r_ptr is the next free slot, so the top lives one below it
    assign w_top_idx = r_ptr - PW'(1);
    assign top       = r_mem[w_top_idx];
    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (push) begin
            r_ptr <= r_ptr + PW'(1);
            if (!full) begin
                r_count <= r_count + CW'(1);
            end
        end else if (pop && !empty) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_target_unit.sv
// rtl/pc_target_unit.sv - registered next-PC / jump-target generator with return-address prediction
module pc_target_unit
    import pc_target_pkg::*;
#(
    parameter int WORD_SIZE    = DEF_WORD_SIZE,
    parameter int JUMP_FIELD_W = DEF_JUMP_FIELD_W,
    parameter int RAS_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_mode,
    input  logic [WORD_SIZE-1:0]    in_pc,
    input  logic [WORD_SIZE-1:0]    in_offset,
    input  logic [JUMP_FIELD_W-1:0] in_jfield,
    input  logic [WORD_SIZE-1:0]    in_reg,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_SIZE-1:0]    out_target,
    output logic [WORD_SIZE-1:0]    out_link,
    output logic                    out_ras_hit,
    output logic                    out_ras_empty
);
    logic                 w_accept;
    logic [WORD_SIZE-1:0] w_link;
    logic [WORD_SIZE-1:0] w_target;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_hit;
    logic                 w_empty;
    logic [WORD_SIZE-1:0] w_ras_top;
    logic                 w_ras_empty;
    logic                 w_unused_ras_full;

    assign in_ready = !out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_link   = in_pc + WORD_SIZE'(1);

    // Unknown encodings fall through to the sequential default with no stack effect
    always_comb begin
        w_target = w_link;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_hit    = 1'b0;
        w_empty  = 1'b0;
        case (in_mode)
            SEQ:    w_target = w_link;
            BRANCH: w_target = w_link + in_offset;
            JMP:    w_target = {in_pc[WORD_SIZE-1:JUMP_FIELD_W], in_jfield};
            JAL: begin
                w_target = {in_pc[WORD_SIZE-1:JUMP_FIELD_W], in_jfield};
                w_push   = w_accept;
            end
            JR:     w_target = in_reg;
            RET: begin
                w_target = in_reg;
                w_pop    = w_accept;
                w_hit    = !w_ras_empty && (w_ras_top == in_reg);
                w_empty  = w_ras_empty;
            end
            default: w_target = w_link;
        endcase
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (WORD_SIZE)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_link),
        .top       (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_unused_ras_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            out_target    <= '0;
            out_link      <= '0;
            out_ras_hit   <= 1'b0;
            out_ras_empty <= 1'b0;
        end else if (w_accept) begin
            out_valid     <= 1'b1;
            out_target    <= w_target;
            out_link      <= w_link;
            out_ras_hit   <= w_hit;
            out_ras_empty <= w_empty;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_target_unit.sv
// tb/tb_pc_target_unit.sv - randomized and directed checks against a queue-based reference model
module tb_pc_target_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_mode;
    logic [15:0] in_pc;
    logic [15:0] in_offset;
    logic [11:0] in_jfield;
    logic [15:0] in_reg;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_target;
    logic [15:0] out_link;
    logic        out_ras_hit;
    logic        out_ras_empty;

    int checks = 0;
    int errors = 0;

    bit          mv;
    logic [15:0] e_tgt;
    logic [15:0] e_link;
    bit          e_hit;
    bit          e_empty;
    logic [15:0] ras_q[$];

    pc_target_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mode       (in_mode),
        .in_pc         (in_pc),
        .in_offset     (in_offset),
        .in_jfield     (in_jfield),
        .in_reg        (in_reg),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_target    (out_target),
        .out_link      (out_link),
        .out_ras_hit   (out_ras_hit),
        .out_ras_empty (out_ras_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(mv));
        if (mv) begin
            check("out_target", 32'(out_target), 32'(e_tgt));
            check("out_link", 32'(out_link), 32'(e_link));
            check("out_ras_hit", 32'(out_ras_hit), 32'(e_hit));
            check("out_ras_empty", 32'(out_ras_empty), 32'(e_empty));
        end
    endtask

    // One cycle: check what is registered, drive new inputs, advance the model, wait a cycle
    task automatic step(input bit v, input int mode, input logic [15:0] pc, input logic [15:0] off,
                        input logic [11:0] jf, input logic [15:0] rg, input bit fl, input bit rdy);
        bit acc;
        int m;
        check_outputs();
        in_valid  = v;
        in_mode   = 3'(mode);
        in_pc     = pc;
        in_offset = off;
        in_jfield = jf;
        in_reg    = rg;
        flush     = fl;
        out_ready = rdy;
        #1;
        check("in_ready", 32'(in_ready), 32'(!mv || rdy));
        acc = v && (!mv || rdy);
        m = (mode > 5) ? 0 : mode;
        if (acc) begin
            e_link = pc + 16'd1;
            case (m)
                0: e_tgt = pc + 16'd1;
                1: e_tgt = 16'(int'(pc) + 1 + int'($signed(off)));
                2, 3: e_tgt = (pc & 16'hF000) | {4'h0, jf};
                default: e_tgt = rg;
            endcase
            e_hit   = (m == 5) && (ras_q.size() > 0) && (ras_q[$] == rg);
            e_empty = (m == 5) && (ras_q.size() == 0);
            mv = 1'b1;
        end else if (rdy) begin
            mv = 1'b0;
        end
        if (fl) begin
            ras_q.delete();
        end else if (acc && m == 3) begin
            ras_q.push_back(pc + 16'd1);
            if (ras_q.size() > 4) void'(ras_q.pop_front());
        end else if (acc && m == 5 && ras_q.size() > 0) begin
            void'(ras_q.pop_back());
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 0, 16'h0, 16'h0, 12'h0, 16'h0, 1'b0, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; in_mode = 3'd0; in_pc = '0;
        in_offset = '0; in_jfield = '0; in_reg = '0; out_ready = 1'b1;
        mv = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_target", 32'(out_target), 32'd0);
        check("rst_link", 32'(out_link), 32'd0);
        check("rst_hit", 32'(out_ras_hit), 32'd0);
        check("rst_empty", 32'(out_ras_empty), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        step(1'b1, 0, 16'h00FF, 16'h0, 12'h0, 16'h0, 1'b0, 1'b1);
        check("t1_seq", 32'(out_target), 32'h0100);
        step(1'b1, 1, 16'h0010, 16'hFFFC, 12'h0, 16'h0, 1'b0, 1'b1);
        check("t1_branch", 32'(out_target), 32'h000D);
        step(1'b1, 1, 16'hFFFE, 16'h0003, 12'h0, 16'h0, 1'b0, 1'b1);
        check("t2_wrap", 32'(out_target), 32'h0002);
        step(1'b1, 2, 16'hA123, 16'h0, 12'h456, 16'h0, 1'b0, 1'b1);
        check("t2_jmp", 32'(out_target), 32'hA456);

        step(1'b1, 3, 16'h1000, 16'h0, 12'h200, 16'h0, 1'b0, 1'b1);
        check("t3_jal_tgt", 32'(out_target), 32'h1200);
        check("t3_jal_link", 32'(out_link), 32'h1001);
        step(1'b1, 5, 16'h1200, 16'h0, 12'h0, 16'h1001, 1'b0, 1'b1);
        check("t3_ret_hit", 32'(out_ras_hit), 32'd1);
        step(1'b1, 5, 16'h1300, 16'h0, 12'h0, 16'h1001, 1'b0, 1'b1);
        check("t3_ret2_empty", 32'(out_ras_empty), 32'd1);
        check("t3_ret2_hit", 32'(out_ras_hit), 32'd0);

        for (int i = 0; i < 5; i++)
            step(1'b1, 3, 16'(i), 16'h0, 12'h0, 16'h0, 1'b0, 1'b1);
        for (int i = 5; i >= 2; i--) begin
            step(1'b1, 5, 16'h0800, 16'h0, 12'h0, 16'(i), 1'b0, 1'b1);
            check("t4_ovf_hit", 32'(out_ras_hit), 32'd1);
        end
        step(1'b1, 5, 16'h0800, 16'h0, 12'h0, 16'h1, 1'b0, 1'b1);
        check("t4_ovf_empty", 32'(out_ras_empty), 32'd1);

        step(1'b1, 3, 16'h3000, 16'h0, 12'h0AB, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3, 16'h3100, 16'h0, 12'h0CD, 16'h0, 1'b0, 1'b0);
            check("t5_stall_tgt", 32'(out_target), 32'h30AB);
        end
        step(1'b1, 3, 16'h3100, 16'h0, 12'h0CD, 16'h0, 1'b0, 1'b1);
        check("t5_release_tgt", 32'(out_target), 32'h30CD);
        idle();

        step(1'b1, 3, 16'h2000, 16'h0, 12'h345, 16'h0, 1'b1, 1'b1);
        check("t6_flush_tgt", 32'(out_target), 32'h2345);
        check("t6_flush_link", 32'(out_link), 32'h2001);
        step(1'b1, 5, 16'h2400, 16'h0, 12'h0, 16'h2001, 1'b0, 1'b1);
        check("t6_flush_empty", 32'(out_ras_empty), 32'd1);

        for (int i = 0; i < 400; i++) begin
            logic [15:0] rg;
            rg = ($urandom_range(0, 1) == 1 && ras_q.size() > 0) ? ras_q[$] : 16'($urandom);
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                 12'($urandom), rg, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end
        idle();

        step(1'b1, 3, 16'h4000, 16'h0, 12'h111, 16'h0, 1'b0, 1'b1);
        in_valid = 1'b1;
        out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_rst", 32'(out_valid), 32'd0);
        mv = 1'b0;
        ras_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        step(1'b1, 5, 16'h4100, 16'h0, 12'h0, 16'h4001, 1'b0, 1'b1);
        check("t6_rst_ras_empty", 32'(out_ras_empty), 32'd1);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
